rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_pkg.sv | 16 +
 rtl/rst_sync.sv | 22 ++
 rtl/rst_seq.sv | 125 ++++++++++++
 tb/tb_rst_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared FSM state type, synchroniser depth floor and helper for rst_seq
package rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_REL,
    ST_RUN
  } rst_state_e;

  localparam int RST_MIN_SYNC_STAGES = 2;

  function automatic int rst_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// rtl/rst_sync.sv - reset release synchroniser: async assert, SYNC_STAGES-flop release
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - sequenced per-channel reset release; RST_SEQ_SWRST_EN adds sw_rst_req
module rst_seq
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CH_NUM      = 4,
  parameter int MIN_ASSERT  = 16,
  parameter int GAP_CYC     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RST_SEQ_SWRST_EN
  input  logic              sw_rst_req,
`endif
  output logic [CH_NUM-1:0] rst_n_out,
  output logic              rst_done
);

  localparam int CW  = $clog2(rst_max(MIN_ASSERT, GAP_CYC) + 1);
  localparam int CHW = $clog2(CH_NUM) + 1;
  localparam logic [CW-1:0]     MIN_C  = CW'(MIN_ASSERT);
  localparam logic [CW-1:0]     GAP_C  = CW'(GAP_CYC);
  localparam logic [CHW-1:0]    LAST_C = CHW'(CH_NUM - 1);
  localparam logic [CH_NUM-1:0] ONE    = CH_NUM'(1);

  if (SYNC_STAGES < RST_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("rst_seq: SYNC_STAGES below minimum");
  end
  if (CH_NUM < 1 || MIN_ASSERT < 1 || GAP_CYC < 1) begin : g_bad_param
    $error("rst_seq: CH_NUM, MIN_ASSERT and GAP_CYC must be >= 1");
  end

  logic sw_req;
`ifdef RST_SEQ_SWRST_EN
  assign sw_req = sw_rst_req;
`else
  assign sw_req = 1'b0;
`endif

  logic rst_n_sync;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync)
  );

  rst_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [CH_NUM-1:0] out_q, out_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      ch_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // cnt_q counts the hold period in HOLD and the inter-channel gap in REL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    out_d   = out_q;
    done_d  = done_q;
    if (sw_req && state_q != ST_HOLD) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      ch_d    = '0;
      out_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!rst_n_sync || sw_req) begin
            cnt_d = '0;
          end else if (cnt_q + CW'(1) == MIN_C) begin
            cnt_d = '0;
            out_d = ONE;
            if (CH_NUM == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_REL;
              ch_d    = CHW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_REL: begin
          if (cnt_q + CW'(1) == GAP_C) begin
            cnt_d = '0;
            out_d = out_q | (ONE << ch_q);
            if (ch_q == LAST_C) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              ch_d = ch_q + CHW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_RUN: ;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  assign rst_n_out = out_q;
  assign rst_done  = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - scoreboard bench for rst_seq (default and CH_NUM=1 instances)
module tb_rst_seq;

  typedef struct {
    int ch;
    int at;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
`ifdef RST_SEQ_SWRST_EN
  logic       sw_rst_req = 1'b0;
`endif
  logic [3:0] out0;
  logic       done0;
  logic [0:0] out1;
  logic       done1;

  always #5 clk = ~clk;

  rst_seq u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef RST_SEQ_SWRST_EN
    .sw_rst_req (sw_rst_req),
`endif
    .rst_n_out  (out0),
    .rst_done   (done0)
  );

  rst_seq #(.SYNC_STAGES(3), .CH_NUM(1), .MIN_ASSERT(1), .GAP_CYC(8)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef RST_SEQ_SWRST_EN
    .sw_rst_req (sw_rst_req),
`endif
    .rst_n_out  (out1),
    .rst_done   (done1)
  );

  int    errors = 0;
  int    checks = 0;
  int    edge_cnt = 0;
  bit    fall_ok = 1'b0;
  item_t sb0[$];
  item_t sb1[$];
  logic [4:0] prev0 = '0;
  logic [1:0] prev1 = '0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  task automatic rise(input int d, input int ch);
    item_t it;
    if (d == 0) begin
      if (sb0.size() == 0) check($sformatf("d0_extra_rise_%0d", ch), edge_cnt, -1);
      else begin
        it = sb0.pop_front();
        check("d0_order", ch, it.ch);
        check($sformatf("d0_edge_%0d", ch), edge_cnt, it.at);
      end
    end else begin
      if (sb1.size() == 0) check($sformatf("d1_extra_rise_%0d", ch), edge_cnt, -1);
      else begin
        it = sb1.pop_front();
        check("d1_order", ch, it.ch);
        check($sformatf("d1_edge_%0d", ch), edge_cnt, it.at);
      end
    end
  endtask

  task automatic run(input int n);
    logic [4:0] cur0;
    logic [1:0] cur1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_cnt++;
      #1;
      cur0 = {done0, out0};
      cur1 = {done1, out1};
      for (int k = 0; k < 5; k++) begin
        if (cur0[k] && !prev0[k]) rise(0, k);
        if (!cur0[k] && prev0[k] && !fall_ok) check($sformatf("d0_fall_%0d", k), edge_cnt, -1);
      end
      for (int k = 0; k < 2; k++) begin
        if (cur1[k] && !prev1[k]) rise(1, k);
        if (!cur1[k] && prev1[k] && !fall_ok) check($sformatf("d1_fall_%0d", k), edge_cnt, -1);
      end
      prev0 = cur0;
      prev1 = cur1;
    end
  endtask

  task automatic push_seqs(input int base0, input int base1);
    for (int k = 0; k < 4; k++) sb0.push_back('{ch: k, at: base0 + 8 * k});
    sb0.push_back('{ch: 4, at: base0 + 24});
    sb1.push_back('{ch: 0, at: base1});
    sb1.push_back('{ch: 1, at: base1});
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_out0"}, out0, 0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_out1"}, out1, 0);
    check({tag, "_done1"}, done1, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_sb0_left"}, sb0.size(), 0);
    check({tag, "_sb1_left"}, sb1.size(), 0);
    check({tag, "_out0_all"}, out0, 15);
    check({tag, "_done0_end"}, done0, 1);
    check({tag, "_done1_end"}, done1, 1);
  endtask

  task automatic async_reset_restart(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_low(tag);
    prev0 = '0;
    prev1 = '0;
    sb0.delete();
    sb1.delete();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_cnt = 0;
    push_seqs(18, 4);
  endtask

  initial begin
    int t;
    repeat (5) @(posedge clk);
    #1;
    check_all_low("reset");
    rst_n = 1'b1;
    edge_cnt = 0;
    push_seqs(18, 4);
    run(48);
    check_drained("por");

    async_reset_restart("rst_run");
    run(29);
    check("midrel_sb0", sb0.size(), 3);
    async_reset_restart("rst_midrel");
    run(48);
    check_drained("restart");

`ifdef RST_SEQ_SWRST_EN
    sw_rst_req = 1'b1;
    fall_ok = 1'b1;
    run(1);
    t = edge_cnt;
    sw_rst_req = 1'b0;
    check_all_low("sw1");
    fall_ok = 1'b0;
    push_seqs(t + 16, t + 1);
    run(45);
    check_drained("sw1");

    sw_rst_req = 1'b1;
    fall_ok = 1'b1;
    run(1);
    t = edge_cnt;
    check_all_low("sw10");
    run(9);
    check_all_low("sw10_held");
    sw_rst_req = 1'b0;
    fall_ok = 1'b0;
    push_seqs(t + 25, t + 10);
    run(55);
    check_drained("sw10");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
